// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predict unit: decoded branch codes,
// BHT counter init value and index-width helper.
package branch_predict_unit_pkg;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_BLTZ = 6'h08;
    localparam logic [5:0] OP_BGEZ = 6'h09;

    // Weakly-not-taken: 01 for 2-bit counters, 0 for 1-bit.
    function automatic int unsigned ctr_init(int unsigned bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int unsigned bp_log2(int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/branch_predict_unit_branch_cmp.sv
// Combinational branch condition evaluator; signed compares on rs/rt.
// Unknown codes report not-a-branch and not-taken.
module branch_predict_unit_branch_cmp
    import branch_predict_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       code_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             taken_o,
    output logic             is_branch_o
);

    logic a_neg;
    logic a_zero;
    logic a_eq_b;

    assign a_neg  = a_i[WIDTH-1];
    assign a_zero = (a_i == '0);
    assign a_eq_b = (a_i == b_i);

    always_comb begin
        taken_o     = 1'b0;
        is_branch_o = 1'b1;
        unique case (code_i)
            OP_BEQ:  taken_o = a_eq_b;
            OP_BNE:  taken_o = !a_eq_b;
            OP_BLEZ: taken_o = a_neg || a_zero;
            OP_BGTZ: taken_o = !a_neg && !a_zero;
            OP_BLTZ: taken_o = a_neg;
            OP_BGEZ: taken_o = !a_neg;
            default: is_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus BHT-based dynamic prediction: IF-stage lookup,
// D-stage resolve/train, and saturating branch/mispredict statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2,
    parameter int PC_LSB    = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     if_pc_in,
    output logic                 pred_taken_out,
    input  logic                 res_valid_in,
    input  logic [WIDTH-1:0]     res_pc_in,
    input  logic [5:0]           instr_code_in,
    input  logic [WIDTH-1:0]     srcA,
    input  logic [WIDTH-1:0]     srcB,
    input  logic                 res_pred_taken_in,
    output logic                 branch_out,
    output logic                 mispredict_out,
    output logic [STAT_BITS-1:0] branch_cnt_out,
    output logic [STAT_BITS-1:0] mispredict_cnt_out
);

    localparam int IDX_W = bp_log2(BHT_DEPTH);
    localparam logic [CTR_BITS-1:0] CTR_INIT =
        CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0]  bht_q [BHT_DEPTH];
    logic [CTR_BITS-1:0]  ctr_q;
    logic [CTR_BITS-1:0]  ctr_d;
    logic [STAT_BITS-1:0] br_cnt_q;
    logic [STAT_BITS-1:0] br_cnt_d;
    logic [STAT_BITS-1:0] mp_cnt_q;
    logic [STAT_BITS-1:0] mp_cnt_d;
    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     res_idx;
    logic                 taken;
    logic                 is_branch;
    logic                 upd;
    logic                 mispred;
    logic                 unused_pc;

    assign if_idx    = if_pc_in[PC_LSB +: IDX_W];
    assign res_idx   = res_pc_in[PC_LSB +: IDX_W];
    assign unused_pc = ^{if_pc_in, res_pc_in};

    branch_predict_unit_branch_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .code_i      (instr_code_in),
        .a_i         (srcA),
        .b_i         (srcB),
        .taken_o     (taken),
        .is_branch_o (is_branch)
    );

    assign upd     = res_valid_in && is_branch;
    assign mispred = upd && (taken != res_pred_taken_in);

    // IF read sees the pre-update value on a same-index collision.
    assign pred_taken_out = bht_q[if_idx][CTR_BITS-1];
    assign ctr_q          = bht_q[res_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (taken) begin
            if (ctr_q != '1) ctr_d = ctr_q + 1'b1;
        end else begin
            if (ctr_q != '0) ctr_d = ctr_q - 1'b1;
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
        if (mispred && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_INIT;
            end
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (upd) bht_q[res_idx] <= ctr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign branch_out         = taken;
    assign mispredict_out     = mispred;
    assign branch_cnt_out     = br_cnt_q;
    assign mispredict_cnt_out = mp_cnt_q;

endmodule
